mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

- Two-master, single-beat arbiter for the SoC memory bus; shares the bus between the CPU (master 0) and a second requester (master 1, DMA or flash loader).
- Drives the bus towards BRAM_MMIO and GPIO_MMIO and returns read data on a registered response cycle.
- Latches the accessed region at grant time, so the read-data mux is decided by the transaction owner rather than a free-running delayed address.
- Flags accesses that decode to no mapped region.

## Interface
- BRAM_BASE, 32'h0000_0000, first BRAM byte address
- BRAM_TOP, 32'h0000_01FF, last BRAM byte address (inclusive)
- GPIO_BASE, 32'hFFFF_FFF0, first GPIO byte address
- GPIO_TOP, 32'hFFFF_FFF3, last GPIO byte address (inclusive)
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- m0_req / m1_req  in  1  master requests a transaction; held until gnt
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_mask / m1_mask  in  4  byte enables
- m0_gnt / m1_gnt  out  1  one-cycle pulse; the request was accepted
- m0_rvalid / m1_rvalid  out  1  one-cycle pulse; transaction complete
- m0_rdata / m1_rdata  out  32  read data, valid with rvalid
- memAddress  out  32  bus address
- memWriteData  out  32  bus write data
- memWrite  out  1  bus write strobe
- byteMask  out  4  bus byte enables
- bramReadData  in  32  BRAM read data, one cycle after address
- gpioReadData  in  32  GPIO read data, one cycle after address
- err  out  1  one-cycle pulse with rvalid when the address is unmapped

## Operation
- States:
  - IDLE: arbitrate.
  - ACCESS: bus driven.
  - RESP: data returned.
- IDLE, any req high:
  - Pick the winner.
  - Register its addr, wdata, we and mask onto the bus outputs.
  - Register owner and decoded region (NONE/BRAM/GPIO).
  - Go to ACCESS.
- IDLE, no req: stay in IDLE.
- ACCESS:
  - Owner's gnt = 1.
  - memWrite = registered we.
  - byteMask = registered mask.
  - Go to RESP.
- RESP:
  - Owner's rvalid = 1.
  - rdata = bramReadData if region BRAM; gpioReadData if region GPIO; 0 if region NONE.
  - Writes also get rvalid, with rdata 0.
  - err = 1 if region NONE.
  - Go to IDLE.
- Non-owner master: gnt, rvalid and rdata stay 0.
- Arbitration is round-robin on a last_owner bit:
  - Single requester wins.
  - On simultaneous requests, the master ≠ last_owner wins.
  - last_owner updates on every grant.
- Region decode is inclusive on both bounds; BRAM is checked before GPIO.
- Outside ACCESS:
  - memWrite = 0 and byteMask = 0.
  - memAddress and memWriteData hold their last value (BRAM read path stays stable).
- A req that drops before gnt is still serviced if it was already sampled in IDLE; masters must hold req until gnt.

## Timing
- Req sampled at edge 0 (IDLE) → gnt and bus valid in cycle 1 → rvalid and rdata in cycle 2 → IDLE in cycle 3.
- Fixed latency: 2 cycles from sample to rvalid.
- Peak throughput: one transaction per 3 cycles.
- Reset values:
  - state = IDLE, last_owner = 1 (so the CPU wins the first conflict).
  - memAddress = 0, memWriteData = 0, memWrite = 0, byteMask = 0.
  - All gnt, rvalid, rdata = 0; err = 0.
- Reset asserted mid-transaction: outputs clear immediately (asynchronously); the transaction is dropped with no rvalid and no err.
- A req held high through RESP is re-arbitrated in the following IDLE cycle.

## Configuration
- MEM_ARB_FIXED_PRIO_EN defined:
  - Master 0 always wins simultaneous requests.
  - last_owner is not implemented.
  - Master 1 may starve.
- Not defined: round-robin as above.

## Structure
- Package mem_bus_pkg:
  - region_e {REG_NONE, REG_BRAM, REG_GPIO}.
  - arb_state_e {IDLE, ACCESS, RESP}.
  - Default address bound constants.
- Sub-module mem_region_decode:
  - Combinational; address plus bounds in, region_e out.
  - Reused later by the SoC read mux.

## Test plan
- Read: m0 reads 32'h0000_0010 with bramReadData = 32'hDEAD_BEEF → m0_gnt in cycle 1 with memAddress = 32'h10, memWrite = 0; m0_rvalid in cycle 2 with m0_rdata = 32'hDEAD_BEEF.
- Write: m1 writes 32'hFFFF_FFF0, wdata 32'h1, mask 4'b0001 → memWrite = 1 and byteMask = 4'h1 for exactly cycle 1; m1_rvalid in cycle 2 with m1_rdata = 0.
- Conflict, round-robin build: m0 and m1 request together from reset, both held → grant order m0, m1, m0, m1, spaced 3 cycles apart.
- Conflict, MEM_ARB_FIXED_PRIO_EN build: same stimulus → m0 is granted every transaction; m1 is never granted.
- Unmapped: m0 reads 32'h0000_1000 → m0_rvalid in cycle 2 with rdata = 0 and err = 1 for that cycle.
- Reset mid-transaction: assert reset in ACCESS → memWrite, gnt and rvalid = 0 immediately; no rvalid after reset release; next req behaves as from reset.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and default address map for the SoC memory bus.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      REG_NONE,
      REG_BRAM,
      REG_GPIO
   } region_e;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } arb_state_e;

   localparam logic [31:0] BRAM_BASE = 32'h0000_0000;
   localparam logic [31:0] BRAM_TOP  = 32'h0000_01FF;
   localparam logic [31:0] GPIO_BASE = 32'hFFFF_FFF0;
   localparam logic [31:0] GPIO_TOP  = 32'hFFFF_FFF3;

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address-to-region decode; bounds are inclusive and BRAM takes precedence over GPIO.
module mem_region_decode
   import mem_bus_pkg::*;
(
   input  logic [31:0] address,
   input  logic [31:0] bramBase,
   input  logic [31:0] bramTop,
   input  logic [31:0] gpioBase,
   input  logic [31:0] gpioTop,
   output region_e     region
);

   // NOTE: assigning a default before any branch keeps this block free of inferred latches.
   always_comb begin
      region = REG_NONE;
      if (address >= bramBase && address <= bramTop)
         region = REG_BRAM;
      else if (address >= gpioBase && address <= gpioTop)
         region = REG_GPIO;
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master single-beat memory bus arbiter: IDLE -> ACCESS -> RESP, round-robin by default.
// Define MEM_ARB_FIXED_PRIO_EN to give master 0 fixed priority instead.
module mem_bus_arbiter
   import mem_bus_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic        m0_we,
   input  logic [3:0]  m0_mask,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic        m1_we,
   input  logic [3:0]  m1_mask,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic [31:0] memAddress,
   output logic [31:0] memWriteData,
   output logic        memWrite,
   output logic [3:0]  byteMask,
   input  logic [31:0] bramReadData,
   input  logic [31:0] gpioReadData,
   output logic        err
);

   arb_state_e  state, nextState;
   logic        owner;
   region_e     region;
   region_e     sampleRegion;
   logic        weReg;
   logic [3:0]  maskReg;
   logic        anyReq;
   logic        winner;
   logic [31:0] respData;

   assign anyReq = m0_req | m1_req;

`ifdef MEM_ARB_FIXED_PRIO_EN
   assign winner = ~m0_req;
`else
   logic lastOwner;

   // On a conflict the master that did not own the previous transaction wins.
   always_comb begin
      if (m0_req && m1_req)
         winner = ~lastOwner;
      else
         winner = ~m0_req;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         lastOwner <= 1'b1;
      else if (state == IDLE && anyReq)
         lastOwner <= winner;
   end
`endif

   mem_region_decode u_decode (
      .address  (winner ? m1_addr : m0_addr),
      .bramBase (BRAM_BASE),
      .bramTop  (BRAM_TOP),
      .gpioBase (GPIO_BASE),
      .gpioTop  (GPIO_TOP),
      .region   (sampleRegion)
   );

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (anyReq) nextState = ACCESS;
         ACCESS:  nextState = RESP;
         RESP:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= nextState;
   end

   // Region and owner are captured with the request so the response mux follows the transaction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         memAddress   <= '0;
         memWriteData <= '0;
         weReg        <= 1'b0;
         maskReg      <= '0;
         owner        <= 1'b0;
         region       <= REG_NONE;
      end else if (state == IDLE && anyReq) begin
         memAddress   <= winner ? m1_addr  : m0_addr;
         memWriteData <= winner ? m1_wdata : m0_wdata;
         weReg        <= winner ? m1_we    : m0_we;
         maskReg      <= winner ? m1_mask  : m0_mask;
         owner        <= winner;
         region       <= sampleRegion;
      end
   end

   always_comb begin
      respData = '0;
      if (!weReg) begin
         case (region)
            REG_BRAM: respData = bramReadData;
            REG_GPIO: respData = gpioReadData;
            default:  respData = '0;
         endcase
      end
   end

   always_comb begin
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      m0_rvalid = 1'b0;
      m1_rvalid = 1'b0;
      m0_rdata  = '0;
      m1_rdata  = '0;
      memWrite  = 1'b0;
      byteMask  = '0;
      err       = 1'b0;
      case (state)
         ACCESS: begin
            m0_gnt   = ~owner;
            m1_gnt   = owner;
            memWrite = weReg;
            byteMask = maskReg;
         end
         RESP: begin
            m0_rvalid = ~owner;
            m1_rvalid = owner;
            m0_rdata  = owner ? '0 : respData;
            m1_rdata  = owner ? respData : '0;
            err       = (region == REG_NONE);
         end
         default: ;
      endcase
   end

endmodule
